program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 46 ++++
 rtl/loader_timer.sv | 24 ++
 rtl/program_loader.sv | 134 +++++++++++++
 tb/tb_program_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types for the program loader: FSM states, sticky error codes and
// the registered control-output bundle derived from the next state.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RECV,
    ST_WRITE,
    ST_VERIFY,
    ST_RELEASE,
    ST_FAIL
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_VERIFY  = 2'b10;

  localparam int SETTLE_CYCLES = 2;

  typedef struct packed {
    logic       s_ready;
    logic       ram_we;
    logic       cpu_hold;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic [1:0] error;
  } ctl_t;

  // Every control output is a pure function of the state being entered, so
  // registering this value keeps all outputs glitch-free and in step with state.
  function automatic ctl_t ctl_for(state_e st, logic [1:0] err);
    ctl_t c;
    c          = '0;
    c.error    = err;
    c.s_ready  = (st == ST_RECV);
    c.ram_we   = (st == ST_WRITE);
    c.busy     = st inside {ST_SETTLE, ST_RECV, ST_WRITE, ST_VERIFY, ST_RELEASE};
    c.cpu_hold = c.busy | (st == ST_FAIL);
    c.cpu_rst  = (st == ST_RELEASE);
    c.done     = (st == ST_RELEASE);
    return c;
  endfunction

endpackage

// File: rtl/loader_timer.sv
// Idle-cycle counter for the receive phase; expired flags the last allowed
// cycle so the FSM can abort on the same edge.
module loader_timer #(
  parameter  int TIMEOUT = 1000000,
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] r_cnt;

  assign expired = (r_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (clr)            r_cnt <= '0;
    else if (en && !expired) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: streams WORDS bytes into RAM with read-back
// verify while holding the CPU, then releases it with a reset pulse.
module program_loader
  import program_loader_pkg::*;
#(
  parameter  int WORDS   = 16,
  parameter  int TIMEOUT = 1000000,
  localparam int AW      = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  input  logic [7:0]    ram_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  output logic          cpu_hold,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic [1:0]    error
);

  localparam int            SW        = $clog2(SETTLE_CYCLES + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  state_e        r_state, w_state_nxt;
  ctl_t          r_ctl, w_ctl_nxt;
  logic [1:0]    w_err_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_wdata, w_wdata_nxt;
  logic [SW-1:0] r_settle, w_settle_nxt;
  logic          r_start, r_start_q;
  logic          w_start_rise, w_hs, w_expired, w_tmr_clr, w_tmr_en;

  // Start passes through one register before edge detection; the history
  // register resets low so a start held across reset release still counts.
  assign w_start_rise = r_start & ~r_start_q;
  assign w_hs         = r_ctl.s_ready & s_valid;
  assign w_tmr_clr    = (r_state != ST_RECV);
  assign w_tmr_en     = (r_state == ST_RECV) & ~w_hs;

  loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_tmr_clr),
    .en     (w_tmr_en),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_wdata_nxt  = r_wdata;
    w_settle_nxt = r_settle;
    w_err_nxt    = r_ctl.error;
    case (r_state)
      ST_IDLE, ST_FAIL: begin
        if (w_start_rise) begin
          w_state_nxt  = ST_SETTLE;
          w_cnt_nxt    = '0;
          w_settle_nxt = '0;
          w_err_nxt    = ERR_NONE;
        end
      end
      ST_SETTLE: begin
        if (r_settle == SW'(SETTLE_CYCLES - 1)) w_state_nxt = ST_RECV;
        else                                    w_settle_nxt = r_settle + 1'b1;
      end
      ST_RECV: begin
        // A byte arriving in the expiry cycle is still accepted.
        if (w_hs) begin
          w_wdata_nxt = s_data;
          w_state_nxt = ST_WRITE;
        end else if (w_expired) begin
          w_state_nxt = ST_FAIL;
          w_err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_WRITE: w_state_nxt = ST_VERIFY;
      ST_VERIFY: begin
        if (ram_rdata != r_wdata) begin
          w_state_nxt = ST_FAIL;
          w_err_nxt   = ERR_VERIFY;
        end else if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = ST_RECV;
        end
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    w_ctl_nxt = ctl_for(w_state_nxt, w_err_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl     <= '0;
      r_cnt     <= '0;
      r_wdata   <= '0;
      r_settle  <= '0;
      r_start   <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_ctl     <= w_ctl_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wdata   <= w_wdata_nxt;
      r_settle  <= w_settle_nxt;
      r_start   <= start;
      r_start_q <= r_start;
    end
  end

  assign s_ready   = r_ctl.s_ready;
  assign ram_we    = r_ctl.ram_we;
  assign cpu_hold  = r_ctl.cpu_hold;
  assign cpu_rst   = r_ctl.cpu_rst;
  assign busy      = r_ctl.busy;
  assign done      = r_ctl.done;
  assign error     = r_ctl.error;
  assign ram_addr  = r_cnt;
  assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_program_loader.sv
// Randomized session bench for program_loader: source/RAM models, a per-cycle
// monitor against a transaction-level expectation, and session outcome checks.
module tb_program_loader;
  localparam int WORDS    = 16;
  localparam int TIMEOUT  = 20;
  localparam int AW       = $clog2(WORDS);
  // Start first sampled at edge 0; done registered at edge 51 and seen on the
  // falling edge after it, i.e. 52 falling edges after start was raised.
  localparam int B2B_DONE = 52;
  localparam int B2B_BUSY = 2 + 3 * WORDS + 1;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_ready, ram_we, cpu_hold, cpu_rst, busy, done;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;
  logic [1:0]    error;

  always #5 clk = ~clk;

  program_loader #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .ram_rdata(ram_rdata), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .cpu_hold(cpu_hold),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM model with an optional stuck-at-0 fault on the read path.
  logic [7:0] mem [WORDS];
  bit         f_en = 0;
  int         f_addr = 0;
  logic [7:0] f_mask = 8'h00;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = (f_en && int'(ram_addr) == f_addr) ? (mem[ram_addr] & ~f_mask)
                                                         : mem[ram_addr];

  // Byte source: sb[] in order, random gaps, optional stall of one byte.
  logic [7:0] sb [WORDS];
  int src_limit = 0, src_idx = 0, gap_pct = 0, idle_run = 0;
  int dly_idx = -1, dly_len = 0, dly_cnt = 0;
  bit hs_pend = 0, src_rst = 0, src_give = 0;

  initial forever begin
    @(negedge clk);
    if (src_rst) begin
      src_idx = 0; hs_pend = 0; dly_cnt = 0; idle_run = 0; src_rst = 0;
    end else if (hs_pend) src_idx++;
    src_give = 0;
    if (src_idx < src_limit) begin
      if (src_idx == dly_idx && dly_cnt < dly_len) begin
        if (s_ready) dly_cnt++;
      end else begin
        src_give = (idle_run >= 8) || (int'($urandom_range(99)) >= gap_pct);
      end
    end
    if (src_give) begin
      s_valid = 1'b1; s_data = sb[src_idx]; idle_run = 0;
    end else begin
      s_valid = 1'b0; s_data = 8'($urandom); idle_run++;
    end
    hs_pend = s_valid && s_ready;
  end

  // Monitor: checks every cycle against the expected write stream and idle rules.
  int cyc = 0, exp_idx = 0, last_we = -100, done_cnt = 0, done_cyc = 0;
  int busy_cnt = 0, sr_cnt = 0, sr_run = 0, last_run = 0;
  bit mon_en = 0, active = 0, hold_exp = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (busy) busy_cnt++;
      if (s_ready) begin sr_cnt++; sr_run++; end
      else if (sr_run > 0) begin last_run = sr_run; sr_run = 0; end
      chk("done_eq_cpu_rst", cpu_rst, done);
      if (busy)    chk("hold_while_busy", cpu_hold, 1);
      if (s_ready) chk("ready_only_busy", busy, 1);
      if (ram_we) begin
        chk("we_spacing_ge3", (cyc - last_we) >= 3, 1);
        last_we = cyc;
        chk("we_not_ready", s_ready, 0);
        chk("wr_addr", ram_addr, exp_idx);
        chk("wr_data", ram_wdata, sb[exp_idx % WORDS]);
        exp_idx++;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        chk("done_after_all_words", exp_idx, WORDS);
      end
      if (!active) begin
        chk("idle_busy", busy, 0);
        chk("idle_we", ram_we, 0);
        chk("idle_ready", s_ready, 0);
        chk("idle_hold", cpu_hold, hold_exp);
      end
    end
  end

  task automatic session(input bit from_reset, input int limit, input int gp,
                         input bit fen, input int fa, input logic [7:0] fm, input int fbyte,
                         input int di, input int dl, input bit toggle, input bit hold_start,
                         input bit b2b, input bit seq);
    int exp_err, exp_k, n_wr, wait_n, st_cyc;
    @(negedge clk); #1;
    for (int k = 0; k < WORDS; k++) sb[k] = seq ? 8'(k) : 8'($urandom);
    if (fbyte >= 0) sb[fa] = 8'(fbyte);
    f_en = fen; f_addr = fa; f_mask = fm;
    src_limit = limit; gap_pct = gp; dly_idx = di; dly_len = dl; src_rst = 1;
    exp_idx = 0; done_cnt = 0; busy_cnt = 0; sr_cnt = 0; sr_run = 0; last_run = 0;
    last_we = -100;
    // Expected outcome from the session rules alone.
    exp_err = 0; exp_k = WORDS;
    for (int k = 0; k < WORDS; k++) begin
      if (k >= limit || (k == di && dl >= TIMEOUT)) begin exp_err = 1; exp_k = k; break; end
      if (fen && k == fa && (sb[k] & fm) != 0)      begin exp_err = 2; exp_k = k; break; end
    end
    n_wr = (exp_err == 2) ? exp_k + 1 : exp_k;
    if (!from_reset) begin
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
    end
    active = 1; start = 1'b1;
    if (from_reset) rst_n = 1'b1;
    st_cyc = cyc;
    wait_n = 0;
    while (!busy && wait_n < 10) begin @(negedge clk); #1; wait_n++; end
    chk("busy_rise", busy, 1);
    chk("error_cleared_on_start", error, 0);
    chk("addr_zero_on_start", ram_addr, 0);
    wait_n = 0;
    while (busy && wait_n < 3000) begin
      if (toggle && exp_err == 0) start = (exp_idx < WORDS - 3) ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clk); #1; wait_n++;
    end
    chk("session_ends", busy, 0);
    if (!(hold_start || (toggle && exp_err == 0))) start = 1'b0;
    hold_exp = (exp_err != 0);
    active = 0;
    repeat (6) @(negedge clk);
    #1;
    chk("error_code", error, exp_err);
    chk("done_count", done_cnt, exp_err == 0);
    chk("write_count", exp_idx, n_wr);
    chk("cpu_hold_after", cpu_hold, exp_err != 0);
    if (exp_err != 0) chk("fail_addr", ram_addr, exp_k);
    if (exp_err == 1) chk("timeout_ready_cycles", last_run, TIMEOUT);
    for (int k = 0; k < n_wr; k++) chk("ram_content", mem[k], sb[k]);
    if (b2b) begin
      chk("b2b_done_cycle", done_cyc - st_cyc, B2B_DONE);
      chk("b2b_busy_cycles", busy_cnt, B2B_BUSY);
      chk("b2b_ready_cycles", sr_cnt, WORDS);
    end
    src_limit = 0; dly_idx = -1; dly_len = 0;
  endtask

  task automatic reset_mid();
    int wait_n;
    @(negedge clk); #1;
    for (int k = 0; k < WORDS; k++) sb[k] = 8'($urandom);
    f_en = 0; src_limit = WORDS; gap_pct = 0; dly_idx = -1; src_rst = 1;
    exp_idx = 0; last_we = -100;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    active = 1; start = 1'b1;
    wait_n = 0;
    while (!(ram_we && ram_addr == AW'(9)) && wait_n < 300) begin
      @(negedge clk); #1; wait_n++;
    end
    chk("reached_write_9", ram_we && ram_addr == AW'(9), 1);
    mon_en = 0; rst_n = 1'b0;
    #1;
    chk("arst_s_ready", s_ready, 0);  chk("arst_ram_we", ram_we, 0);
    chk("arst_ram_addr", ram_addr, 0); chk("arst_ram_wdata", ram_wdata, 0);
    chk("arst_cpu_hold", cpu_hold, 0); chk("arst_cpu_rst", cpu_rst, 0);
    chk("arst_busy", busy, 0);         chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    for (int k = 0; k < 9; k++) chk("partial_ram_kept", mem[k], sb[k]);
    start = 1'b0; src_limit = 0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1; active = 0; hold_exp = 0; mon_en = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);   chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0); chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_error", error, 0);       chk("rst_cpu_rst", cpu_rst, 0);
    mon_en = 1;
    // Start held across reset release, bytes 0x00..0x0F back-to-back.
    session(1, WORDS, 0, 0, 0, 8'h00, -1, -1, 0, 0, 0, 1, 1);
    chk("lit_ok_hold_released", cpu_hold, 0);
    // Source stops after 5 bytes.
    session(0, 5, 0, 0, 0, 8'h00, -1, -1, 0, 0, 0, 0, 1);
    chk("lit_timeout_err", error, 2'b01);
    chk("lit_timeout_addr", ram_addr, 5);
    chk("lit_timeout_busy", busy, 0);
    // Bit 3 stuck at 0 at address 7, byte 0x08 written there.
    session(0, WORDS, 0, 1, 7, 8'h08, 8'h08, -1, 0, 0, 0, 0, 1);
    chk("lit_verify_err", error, 2'b10);
    chk("lit_verify_addr", ram_addr, 7);
    // Restart from FAIL, start toggled while busy and left high past done.
    session(0, WORDS, 30, 0, 0, 8'h00, -1, -1, 0, 1, 1, 0, 0);
    // Byte in the last allowed RECV cycle wins; one cycle later times out.
    session(0, WORDS, 0, 0, 0, 8'h00, -1, 3, TIMEOUT - 1, 0, 0, 0, 0);
    session(0, WORDS, 0, 0, 0, 8'h00, -1, 3, TIMEOUT, 0, 0, 0, 0);
    reset_mid();
    session(0, WORDS, 20, 0, 0, 8'h00, -1, -1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(2));
      session(0, (r == 0) ? int'($urandom_range(WORDS - 1)) : WORDS,
              int'($urandom_range(60)), r == 1, int'($urandom_range(WORDS - 1)),
              8'(1 << $urandom_range(7)), -1, -1, 0, r == 2, 1'($urandom_range(1)), 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
